piso_serializer: RTL

Parallel-in, serial-out serializer that feeds the three-consecutive-ones detector stage its `sin` bit stream. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. A one-word holding register lets back-to-back words stream with no idle cycles between them. It is the stage directly upstream of the detector; `sout` connects to the detector's serial input.

---
 rtl/piso_serializer_if.sv | 22 ++
 rtl/piso_serializer.sv | 114 +++++++++++
 2 files changed

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus between a word producer and the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding register so
// back-to-back words stream out with no idle bit between them.
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  piso_serializer_if.slave      bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             din_ready_q, din_ready_d;

  logic             accept;
  logic             shifter_free;

  // State and output registers; reset discards any word in flight or held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      din_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      din_ready_q  <= din_ready_d;
    end
  end

  // Load priority: drain hold, else bypass into the shifter, else fill hold,
  // else retire or keep shifting; outputs are precomputed from next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    accept       = bus.din_valid && din_ready_q;
    shifter_free = (state_q == IDLE) || (cnt_q == CNT_LAST);

    if (shifter_free && hold_full_q) begin
      sh_d        = hold_q;
      cnt_d       = '0;
      state_d     = SHIFT;
      hold_full_d = 1'b0;
    end else if (shifter_free && accept) begin
      sh_d    = bus.din;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (accept) begin
      hold_d      = bus.din;
      hold_full_d = 1'b1;
      if (state_q == SHIFT) begin
        cnt_d = cnt_q + CNT_W'(1);
        sh_d  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
      end
    end else if (shifter_free) begin
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      sh_d  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
    end

    sout_valid_d = (state_d == SHIFT);
    last_d       = (state_d == SHIFT) && (cnt_d == CNT_LAST);
    busy_d       = (state_d == SHIFT) || hold_full_d;
    din_ready_d  = !hold_full_d;
    if (state_d == SHIFT) begin
      sout_d = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];
    end else begin
      sout_d = IDLE_LEVEL;
    end
  end

  assign bus.din_ready  = din_ready_q;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.last       = last_q;
  assign bus.busy       = busy_q;

endmodule
